// File: rtl/ex_madd.sv
// Multi-cycle MADD/MADDU/MSUB/MSUBU sequencer for the EX stage: {HI,LO} +/- rs*rt.
// Define MADD_SHIFTADD_EN to replace the single-cycle multiply with a 32-step shift-add.
module ex_madd #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              hold_i,
    input  logic              cancel_i,
    output logic              stallreq_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              whilo_o
);

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t                state;
    logic                  sub_r;
    logic [DATA_W-1:0]     a_r;
    logic [DATA_W-1:0]     b_r;
    logic [2*DATA_W-1:0]   prod_r;
    logic [2*DATA_W-1:0]   acc_res;

`ifdef MADD_SHIFTADD_EN
    localparam int CNT_W = $clog2(DATA_W);
    logic [CNT_W-1:0]      cnt;
    logic                  neg_r;
    logic [2*DATA_W-1:0]   term;
    logic [2*DATA_W-1:0]   part_sum;

    always_comb begin
        term = '0;
        if (b_r[cnt])
            term = {{DATA_W{1'b0}}, a_r} << cnt;
        part_sum = prod_r + term;
    end
`else
    logic                  sgn_r;
    logic [2*DATA_W-1:0]   a_ext;
    logic [2*DATA_W-1:0]   b_ext;

    // Extending both operands to 2*DATA_W makes the truncated product correct for signed and unsigned.
    always_comb begin
        a_ext = {{DATA_W{sgn_r & a_r[DATA_W-1]}}, a_r};
        b_ext = {{DATA_W{sgn_r & b_r[DATA_W-1]}}, b_r};
    end
`endif

    always_comb begin
        acc_res = sub_r ? ({hi_i, lo_i} - prod_r) : ({hi_i, lo_i} + prod_r);
    end

    always_comb begin
        stallreq_o = 1'b0;
        if (!rst)
            stallreq_o = ((state == IDLE) && start_i) || (state == MUL) || (state == ACC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sub_r   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            prod_r  <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
            whilo_o <= 1'b0;
`ifdef MADD_SHIFTADD_EN
            cnt     <= '0;
            neg_r   <= 1'b0;
`else
            sgn_r   <= 1'b0;
`endif
        end else if (cancel_i) begin
            state   <= IDLE;
            whilo_o <= 1'b0;
`ifdef MADD_SHIFTADD_EN
            cnt     <= '0;
`endif
        end else if (!hold_i) begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sub_r <= op_i[1];
                        state <= MUL;
`ifdef MADD_SHIFTADD_EN
                        // Iterate on magnitudes; the sign is reapplied on the last step.
                        a_r    <= (!op_i[0] && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
                        b_r    <= (!op_i[0] && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
                        neg_r  <= !op_i[0] && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        prod_r <= '0;
                        cnt    <= '0;
`else
                        a_r    <= opdata1_i;
                        b_r    <= opdata2_i;
                        sgn_r  <= !op_i[0];
`endif
                    end
                end
                MUL: begin
`ifdef MADD_SHIFTADD_EN
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        prod_r <= neg_r ? -part_sum : part_sum;
                        state  <= ACC;
                    end else begin
                        prod_r <= part_sum;
                    end
`else
                    prod_r <= a_ext * b_ext;
                    state  <= ACC;
`endif
                end
                ACC: begin
                    {hi_o, lo_o} <= acc_res;
                    whilo_o      <= 1'b1;
                    state        <= DONE;
                end
                default: begin
                    whilo_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_madd.sv
// Self-checking bench for ex_madd: directed cases plus random ops against a 64-bit arithmetic model.
module tb_ex_madd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [31:0] hi_i = '0;
    logic [31:0] lo_i = '0;
    logic        hold_i = 1'b0;
    logic        cancel_i = 1'b0;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;

    int checks = 0;
    int fails = 0;

`ifdef MADD_SHIFTADD_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 3;
`endif

    ex_madd #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
        .hold_i(hold_i), .cancel_i(cancel_i), .stallreq_o(stallreq_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint p;
        longint acc;
        if (op[0])
            p = longint'({32'd0, a}) * longint'({32'd0, b});
        else
            p = longint'($signed(a)) * longint'($signed(b));
        acc = longint'({hi, lo});
        return op[1] ? 64'(acc - p) : 64'(acc + p);
    endfunction

    // Issue one op; HI/LO switch to hi1/lo1 once the unit is past IDLE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi0, input logic [31:0] lo0,
                          input logic [31:0] hi1, input logic [31:0] lo1);
        int cyc;
        logic [63:0] exp;
        exp = model(op, a, b, hi1, lo1);
        op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi0; lo_i = lo0;
        start_i = 1'b1;
        #1;
        check({tag, "_stall_start"}, 64'(stallreq_o), 64'd1);
        tick();
        start_i = 1'b0; opdata1_i = $urandom; opdata2_i = $urandom; op_i = 2'($urandom);
        hi_i = hi1; lo_i = lo1;
        cyc = 1;
        while (!whilo_o && cyc < 60) begin
            if (stallreq_o !== 1'b1)
                check({tag, "_stall_busy"}, 64'(stallreq_o), 64'd1);
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
        check({tag, "_whilo"}, 64'(whilo_o), 64'd1);
        check({tag, "_result"}, {hi_o, lo_o}, exp);
        check({tag, "_stall_done"}, 64'(stallreq_o), 64'd0);
        tick();
        check({tag, "_whilo_drop"}, 64'(whilo_o), 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, rh, rl, rh1, rl1;
        logic [63:0] exp;

        // Reset state
        start_i = 1'b1;
        tick(); tick();
        check("rst_stall_forced", 64'(stallreq_o), 64'd0);
        check("rst_whilo", 64'(whilo_o), 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        start_i = 1'b0;
        rst = 1'b0;
        #1;
        check("idle_stall", 64'(stallreq_o), 64'd0);

        // Directed cases
        run_op("madd_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd10, 32'd0, 32'd10);
        run_op("msubu_ff", 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        run_op("madd_wrap", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 32'd0,
               32'hC000_0000, 32'd0);
        run_op("msub_fwd", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd5);
        check("msub_fwd_lo", 64'(lo_o), 64'd6);

        // Hold entering ACC, then hold across DONE
        op_i = 2'b01; opdata1_i = 32'd7; opdata2_i = 32'd9; hi_i = 32'd1; lo_i = 32'd2;
        exp = model(2'b01, 32'd7, 32'd9, 32'd1, 32'd2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < LAT - 2; i++) tick();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_acc_whilo", 64'(whilo_o), 64'd0);
            check("hold_acc_stall", 64'(stallreq_o), 64'd1);
        end
        hold_i = 1'b0;
        tick();
        check("hold_done_whilo", 64'(whilo_o), 64'd1);
        check("hold_done_result", {hi_o, lo_o}, exp);
        hold_i = 1'b1;
        hi_i = 32'hDEAD_BEEF; lo_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_done_keep", {31'd0, whilo_o, hi_o, lo_o} , {31'd0, 1'b1, exp});
        end
        start_i = 1'b1;
        #1;
        check("done_stall_start", 64'(stallreq_o), 64'd0);
        start_i = 1'b0;
        hold_i = 1'b0;
        tick();
        check("hold_release_idle", 64'(whilo_o), 64'd0);
        check("hold_release_stall", 64'(stallreq_o), 64'd0);

        // Cancel during MUL
        op_i = 2'b00; opdata1_i = 32'd5; opdata2_i = 32'd6;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        check("cancel_stall", 64'(stallreq_o), 64'd0);
        for (int i = 0; i < LAT + 3; i++) begin
            if (whilo_o !== 1'b0) check("cancel_whilo", 64'(whilo_o), 64'd0);
            tick();
        end
        check("cancel_whilo_end", 64'(whilo_o), 64'd0);

        // Reset during ACC
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < LAT - 2; i++) tick();
        rst = 1'b1;
        #1;
        check("rst_acc_stall", 64'(stallreq_o), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_acc_idle", 64'(stallreq_o), 64'd0);
        for (int i = 0; i < LAT + 3; i++) begin
            if (whilo_o !== 1'b0) check("rst_acc_whilo", 64'(whilo_o), 64'd0);
            tick();
        end
        check("rst_acc_whilo_end", {hi_o, lo_o, 31'd0, whilo_o} != 0 ? 64'(whilo_o) : 64'd0, 64'd0);

        // Recovery after cancel/reset, then random ops
        run_op("post_kill", 2'b10, 32'd100, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom); ra = $urandom; rb = $urandom;
            rh = $urandom; rl = $urandom;
            rh1 = (i % 3 == 0) ? 32'($urandom) : rh;
            rl1 = (i % 3 == 0) ? 32'($urandom) : rl;
            run_op("rand", rop, ra, rb, rh, rl, rh1, rl1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
